// File: rtl/bp_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg -- shared definitions for the branch predictor.
//   * counter constants (reset / weakly-taken / strong), computed per CTR_W
//   * bp_entry_t  : one table entry (valid, tag, target, ctr), sized for the
//                   widest legal configuration; unused upper bits stay zero
//   * pc_index / pc_tag : PC slicing helpers
//       index = pc[IDX_W+1:2], tag = pc[IDX_W+TAG_W+1:IDX_W+2]
// -----------------------------------------------------------------------------
package bp_pkg;

  localparam int PC_W      = 32;
  localparam int TAG_MAX_W = 30;
  localparam int CTR_MAX_W = 4;
  localparam int IDX_MAX_W = 8;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [PC_W-1:0]      target;
    logic [CTR_MAX_W-1:0] ctr;
  } bp_entry_t;

  // Weakly not-taken: 2^(ctr_w-1)-1
  function automatic logic [CTR_MAX_W-1:0] ctr_reset(input int ctr_w);
    return CTR_MAX_W'((32'd1 << (ctr_w - 1)) - 32'd1);
  endfunction

  // Weakly taken: 2^(ctr_w-1)
  function automatic logic [CTR_MAX_W-1:0] ctr_weak(input int ctr_w);
    return CTR_MAX_W'(32'd1 << (ctr_w - 1));
  endfunction

  // Strongly taken: 2^ctr_w-1
  function automatic logic [CTR_MAX_W-1:0] ctr_strong(input int ctr_w);
    return CTR_MAX_W'((32'd1 << ctr_w) - 32'd1);
  endfunction

  function automatic logic [IDX_MAX_W-1:0] pc_index(input logic [PC_W-1:0] pc,
                                                    input int idx_w);
    return IDX_MAX_W'((pc >> 2) & ((32'd1 << idx_w) - 32'd1));
  endfunction

  function automatic logic [TAG_MAX_W-1:0] pc_tag(input logic [PC_W-1:0] pc,
                                                  input int idx_w,
                                                  input int tag_w);
    return TAG_MAX_W'((pc >> (idx_w + 2)) & ((32'd1 << tag_w) - 32'd1));
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// -----------------------------------------------------------------------------
// bp_sat_counter -- combinational next value of a CTR_W-bit saturating counter.
//   ctr : current counter value
//   inc : 1 = count up (taken), 0 = count down (not-taken)
//   nxt : next value, clamped at 0 and 2^CTR_W-1 (never wraps)
// -----------------------------------------------------------------------------
module bp_sat_counter #(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr,
  input  logic             inc,
  output logic [CTR_W-1:0] nxt
);

  localparam logic [CTR_W-1:0] CTR_TOP = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_BOT = {CTR_W{1'b0}};

  // Saturating increment / decrement
  always_comb begin
    nxt = ctr;
    if (inc) begin
      if (ctr != CTR_TOP) begin
        nxt = ctr + CTR_W'(1);
      end else begin
        nxt = ctr;
      end
    end else begin
      if (ctr != CTR_BOT) begin
        nxt = ctr - CTR_W'(1);
      end else begin
        nxt = ctr;
      end
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor -- direct-mapped branch target buffer with saturating
// direction counters. State changes happen on the falling edge of clk.
//
// Ports
//   clk        : clock (table written on negedge)
//   reset      : asynchronous, active-low; clears the whole table
//   lk_pc      : fetch PC; lk_hit/lk_taken/lk_target follow combinationally
//   up_valid   : a resolved branch is presented (up_pc, up_taken, up_target)
//   up_force   : unconditional jump; entry written with counter saturated high
//   st_updates, st_mispredicts : statistics outputs, present only when the
//                macro BRANCH_PREDICTOR_STATS_EN is defined
//
// A lookup and an update on the same index in the same cycle see the
// pre-update table; the write lands on the next falling edge.
// -----------------------------------------------------------------------------
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CTR_W   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] lk_pc,
  output logic        lk_hit,
  output logic        lk_taken,
  output logic [31:0] lk_target,
  input  logic        up_valid,
  input  logic [31:0] up_pc,
  input  logic        up_taken,
  input  logic [31:0] up_target,
  input  logic        up_force
`ifdef BRANCH_PREDICTOR_STATS_EN
  ,
  output logic [31:0] st_updates,
  output logic [31:0] st_mispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);

  bp_entry_t            table_r [ENTRIES];
  logic [IDX_W-1:0]     lk_idx_s;
  logic [IDX_W-1:0]     up_idx_s;
  logic [TAG_MAX_W-1:0] lk_tag_s;
  logic [TAG_MAX_W-1:0] up_tag_s;
  logic                 up_hit_s;
  logic [CTR_W-1:0]     ctr_nxt_s;
  logic                 wr_en_s;
  bp_entry_t            wr_entry_s;

  assign lk_idx_s = IDX_W'(pc_index(lk_pc, IDX_W));
  assign up_idx_s = IDX_W'(pc_index(up_pc, IDX_W));
  assign lk_tag_s = pc_tag(lk_pc, IDX_W, TAG_W);
  assign up_tag_s = pc_tag(up_pc, IDX_W, TAG_W);

  // Lookup port: tag compare and prediction, zero latency
  always_comb begin
    lk_hit    = table_r[lk_idx_s].valid && (table_r[lk_idx_s].tag == lk_tag_s);
    lk_taken  = 1'b0;
    lk_target = 32'd0;
    if (lk_hit) begin
      lk_taken  = table_r[lk_idx_s].ctr[CTR_W-1];
      lk_target = table_r[lk_idx_s].target;
    end else begin
      lk_taken  = 1'b0;
      lk_target = 32'd0;
    end
  end

  // Hit detection on the update port
  always_comb begin
    up_hit_s = table_r[up_idx_s].valid && (table_r[up_idx_s].tag == up_tag_s);
  end

  bp_sat_counter #(.CTR_W(CTR_W)) u_ctr (
    .ctr (table_r[up_idx_s].ctr[CTR_W-1:0]),
    .inc (up_taken),
    .nxt (ctr_nxt_s)
  );

  // Build the entry to write back: force, hit-train, allocate or nothing
  always_comb begin
    wr_en_s    = 1'b0;
    wr_entry_s = table_r[up_idx_s];
    if (up_valid) begin
      if (up_force) begin
        wr_en_s           = 1'b1;
        wr_entry_s.valid  = 1'b1;
        wr_entry_s.tag    = up_tag_s;
        wr_entry_s.target = up_target;
        wr_entry_s.ctr    = ctr_strong(CTR_W);
      end else if (up_hit_s) begin
        wr_en_s        = 1'b1;
        wr_entry_s.ctr = CTR_MAX_W'(ctr_nxt_s);
        if (up_taken) begin
          wr_entry_s.target = up_target;
        end else begin
          wr_entry_s.target = table_r[up_idx_s].target;
        end
      end else if (up_taken) begin
        wr_en_s           = 1'b1;
        wr_entry_s.valid  = 1'b1;
        wr_entry_s.tag    = up_tag_s;
        wr_entry_s.target = up_target;
        wr_entry_s.ctr    = ctr_weak(CTR_W);
      end else begin
        // Not-taken miss: table untouched
        wr_en_s = 1'b0;
      end
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Table storage; reset wins over any pending write
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_r[i] <= '{valid:  1'b0,
                        tag:    {TAG_MAX_W{1'b0}},
                        target: 32'd0,
                        ctr:    ctr_reset(CTR_W)};
      end
    end else if (wr_en_s) begin
      table_r[up_idx_s] <= wr_entry_s;
    end
  end

`ifdef BRANCH_PREDICTOR_STATS_EN
  logic        pred_taken_s;
  logic [31:0] pred_target_s;
  logic        mispredict_s;

  // What a lookup of up_pc would have predicted; a miss predicts not-taken
  always_comb begin
    pred_taken_s  = 1'b0;
    pred_target_s = 32'd0;
    if (up_hit_s) begin
      pred_taken_s  = table_r[up_idx_s].ctr[CTR_W-1];
      pred_target_s = table_r[up_idx_s].target;
    end else begin
      pred_taken_s  = 1'b0;
      pred_target_s = 32'd0;
    end
    // Target only matters when the branch was actually taken
    mispredict_s = (pred_taken_s != up_taken) ||
                   (up_taken && (pred_target_s != up_target));
  end

  // Free-running statistics counters, wrap modulo 2^32
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      st_updates     <= 32'd0;
      st_mispredicts <= 32'd0;
    end else if (up_valid) begin
      st_updates <= st_updates + 32'd1;
      if (mispredict_s) begin
        st_mispredicts <= st_mispredicts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
`timescale 1ns/1ps
module tb_branch_predictor;

  localparam int ENTRIES = 16;
  localparam int TAG_W   = 8;
  localparam int CTR_W   = 2;
  localparam int CTR_TOP = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] lk_pc = 32'd0;
  logic        lk_hit;
  logic        lk_taken;
  logic [31:0] lk_target;
  logic        up_valid = 1'b0;
  logic [31:0] up_pc = 32'd0;
  logic        up_taken = 1'b0;
  logic [31:0] up_target = 32'd0;
  logic        up_force = 1'b0;
`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] st_updates;
  logic [31:0] st_mispredicts;
`endif

  branch_predictor #(.ENTRIES(ENTRIES), .TAG_W(TAG_W), .CTR_W(CTR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .lk_pc     (lk_pc),
    .lk_hit    (lk_hit),
    .lk_taken  (lk_taken),
    .lk_target (lk_target),
    .up_valid  (up_valid),
    .up_pc     (up_pc),
    .up_taken  (up_taken),
    .up_target (up_target),
    .up_force  (up_force)
`ifdef BRANCH_PREDICTOR_STATS_EN
    ,
    .st_updates     (st_updates),
    .st_mispredicts (st_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: 16 entries, index pc[5:2], tag pc[13:6]
  bit          m_valid  [ENTRIES];
  int          m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  int          m_upd;
  int          m_mis;
  logic [33:0] sb [$];   // {hit, taken, target}
  int          n_vec = 0;
  int          n_err = 0;

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 0; m_target[i] = 32'd0; m_ctr[i] = 1;
    end
    m_upd = 0; m_mis = 0;
  endfunction

  function automatic logic [33:0] model_lookup(input logic [31:0] pc);
    int i;
    logic h;
    i = int'(pc[5:2]);
    h = m_valid[i] && (m_tag[i] == int'(pc[13:6]));
    return {h, h && (m_ctr[i] >= 2), h ? m_target[i] : 32'd0};
  endfunction

  function automatic void model_update(input logic [31:0] pc, input logic tk,
                                       input logic [31:0] tg, input logic frc);
    int i;
    logic [33:0] p;
    i = int'(pc[5:2]);
    p = model_lookup(pc);
    m_upd++;
    if ((p[32] != tk) || (tk && (p[31:0] != tg))) m_mis++;
    if (frc) begin
      m_valid[i] = 1'b1; m_tag[i] = int'(pc[13:6]); m_target[i] = tg; m_ctr[i] = CTR_TOP;
    end else if (p[33]) begin
      if (tk) begin
        m_ctr[i] = (m_ctr[i] < CTR_TOP) ? m_ctr[i] + 1 : CTR_TOP;
        m_target[i] = tg;
      end else begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end
    end else if (tk) begin
      m_valid[i] = 1'b1; m_tag[i] = int'(pc[13:6]); m_target[i] = tg; m_ctr[i] = 2;
    end
  endfunction

  // One cycle: drive after the falling edge, predict lookup, sample after rising edge
  task automatic drive(input logic [31:0] lpc, input logic uv, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utg, input logic uf);
    @(negedge clk); #1;
    lk_pc = lpc; up_valid = uv; up_pc = upc; up_taken = ut; up_target = utg; up_force = uf;
    sb.push_back(model_lookup(lpc));
    if (uv) model_update(upc, ut, utg, uf);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [33:0] exp;
    lk_pc = 32'h40; up_valid = 1'b1; up_pc = 32'h40; up_taken = 1'b1; up_target = 32'h100;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({lk_hit, lk_taken, lk_target} !== 34'd0) begin
      n_err++; $display("FAIL reset_hold: got %h expected %h", {lk_hit, lk_taken, lk_target}, 34'd0);
    end
    up_valid = 1'b0;
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      drive(32'h40 + 32'(i) * 32'h404, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      exp = sb.pop_front();
      n_vec++;
      if ({lk_hit, lk_taken, lk_target} !== exp || exp !== 34'd0) begin
        n_err++; $display("FAIL after_reset[%0d]: got %h expected %h", i, {lk_hit, lk_taken, lk_target}, exp);
      end
    end
  endtask

  task automatic test_alloc();
    logic [33:0] exp;
    drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0);
    drive(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    void'(sb.pop_front());
    exp = sb.pop_front();
    n_vec++;
    if ({lk_hit, lk_taken, lk_target} !== {1'b1, 1'b1, 32'h100} || exp !== {1'b1, 1'b1, 32'h100}) begin
      n_err++; $display("FAIL alloc: got %h expected %h", {lk_hit, lk_taken, lk_target}, {1'b1, 1'b1, 32'h100});
    end
  endtask

  task automatic test_saturation();
    logic [33:0] exp;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0);
      else if (i < 7) drive(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
      else drive(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      exp = sb.pop_front();
      n_vec++;
      if ({lk_hit, lk_taken, lk_target} !== exp) begin
        n_err++; $display("FAIL saturation[%0d]: got %h expected %h", i, {lk_hit, lk_taken, lk_target}, exp);
      end
    end
    n_vec++;
    if (lk_taken !== 1'b0 || m_ctr[0] != 0) begin
      n_err++; $display("FAIL sat_low: got taken=%0b expected 0", lk_taken);
    end
  endtask

  task automatic test_alias();
    logic [33:0] exp;
    logic [31:0] pcs [4] = '{32'h440, 32'h440, 32'h40, 32'h40};
    for (int i = 0; i < 4; i++) begin
      drive(pcs[i], (i == 1), 32'h440, 1'b0, 32'h0, 1'b0);
      exp = sb.pop_front();
      n_vec++;
      if ({lk_hit, lk_taken, lk_target} !== exp) begin
        n_err++; $display("FAIL alias[%0d]: got %h expected %h", i, {lk_hit, lk_taken, lk_target}, exp);
      end
    end
    n_vec++;
    if (lk_hit !== 1'b1 || lk_target !== 32'h100) begin
      n_err++; $display("FAIL alias_keep: got hit=%0b target=%h expected hit=1 target=100", lk_hit, lk_target);
    end
  endtask

  task automatic test_collision();
    logic [33:0] exp;
    drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h200, 1'b0);
    exp = sb.pop_front();
    n_vec++;
    if ({lk_hit, lk_taken, lk_target} !== exp || lk_target !== 32'h100) begin
      n_err++; $display("FAIL collide_same: got %h expected %h", {lk_hit, lk_taken, lk_target}, exp);
    end
    drive(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    exp = sb.pop_front();
    n_vec++;
    if ({lk_hit, lk_taken, lk_target} !== exp || lk_target !== 32'h200) begin
      n_err++; $display("FAIL collide_next: got %h expected %h", {lk_hit, lk_taken, lk_target}, exp);
    end
  endtask

  task automatic test_force();
    logic [33:0] exp;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drive(32'h80, 1'b1, 32'h80, 1'b1, 32'h500, 1'b1);
      else drive(32'h80, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0);
      exp = sb.pop_front();
      n_vec++;
      if ({lk_hit, lk_taken, lk_target} !== exp) begin
        n_err++; $display("FAIL force[%0d]: got %h expected %h", i, {lk_hit, lk_taken, lk_target}, exp);
      end
    end
    n_vec++;
    if (lk_taken !== 1'b1) begin
      n_err++; $display("FAIL force_strong: got taken=%0b expected 1", lk_taken);
    end
  endtask

  function automatic logic [31:0] pick_pc();
    return (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 3)) << 2);
  endfunction

  task automatic test_random();
    logic [33:0] exp;
    for (int i = 0; i < 200; i++) begin
      drive(pick_pc(), 1'($urandom_range(0, 1)), pick_pc(), 1'($urandom_range(0, 1)),
            {22'd0, 8'($urandom), 2'b00}, ($urandom_range(0, 9) == 0));
      exp = sb.pop_front();
      n_vec++;
      if ({lk_hit, lk_taken, lk_target} !== exp) begin
        n_err++; $display("FAIL random[%0d]: got %h expected %h", i, {lk_hit, lk_taken, lk_target}, exp);
      end
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
  endtask

`ifdef BRANCH_PREDICTOR_STATS_EN
  task automatic test_stats();
    pulse_reset();
    drive(32'h0, 1'b1, 32'hC0, 1'b0, 32'h0, 1'b0);
    drive(32'h0, 1'b1, 32'hC0, 1'b1, 32'h300, 1'b0);
    drive(32'h0, 1'b1, 32'hC0, 1'b1, 32'h300, 1'b0);
    drive(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    repeat (4) void'(sb.pop_front());
    n_vec++;
    if (st_updates !== 32'(m_upd) || st_updates !== 32'd3) begin
      n_err++; $display("FAIL st_updates: got %0d expected %0d", st_updates, 3);
    end
    n_vec++;
    if (st_mispredicts !== 32'(m_mis) || st_mispredicts !== 32'd1) begin
      n_err++; $display("FAIL st_mispredicts: got %0d expected %0d", st_mispredicts, 1);
    end
  endtask
`endif

  // Reset asserted mid-cycle while an update is pending: the update is lost
  task automatic test_reset_mid();
    logic [33:0] exp;
    @(negedge clk); #1;
    lk_pc = 32'h40; up_valid = 1'b1; up_pc = 32'h40; up_taken = 1'b1; up_target = 32'h700; up_force = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_vec++;
    if ({lk_hit, lk_taken, lk_target} !== 34'd0) begin
      n_err++; $display("FAIL reset_mid_lookup: got %h expected %h", {lk_hit, lk_taken, lk_target}, 34'd0);
    end
`ifdef BRANCH_PREDICTOR_STATS_EN
    n_vec++;
    if (st_updates !== 32'd0 || st_mispredicts !== 32'd0) begin
      n_err++; $display("FAIL reset_mid_stats: got %0d/%0d expected 0/0", st_updates, st_mispredicts);
    end
`endif
    @(posedge clk); #1;
    up_valid = 1'b0;
    reset = 1'b1;
    model_reset();
    drive(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    exp = sb.pop_front();
    n_vec++;
    if ({lk_hit, lk_taken, lk_target} !== exp || lk_hit !== 1'b0) begin
      n_err++; $display("FAIL reset_mid_discard: got %h expected %h", {lk_hit, lk_taken, lk_target}, exp);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_alloc();
    test_saturation();
    test_alias();
    test_collision();
    test_force();
    test_random();
`ifdef BRANCH_PREDICTOR_STATS_EN
    test_stats();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
